// File: rtl/find_zero_index_pkg.sv
// Shared constants and sizing helpers for the free-slot finder.
package find_zero_index_pkg;

    localparam int DEF_WIDTH = 4;

    // Index width able to represent 0..width inclusive (width is the sentinel).
    function automatic int idx_w(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int none_idx(input int width);
        return width;
    endfunction

endpackage

// File: rtl/find_zero_index_zero_scan.sv
// Combinational priority scan: lowest position whose bit is 0 and whose mask bit is 1.
module zero_scan
    import find_zero_index_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [WIDTH-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);

    // Walk from MSB down so the lowest qualifying position is the last written.
    always_comb begin
        idx = IDX_W'(none_idx(WIDTH));
        hit = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!vec[i] && mask[i]) begin
                idx = IDX_W'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/find_zero_index.sv
// Registered finder of the two lowest zero bits of a vector (one-cycle latency).
// Optional zero-count output enabled by defining FIND_ZERO_INDEX_COUNT_EN.
module find_zero_index
    import find_zero_index_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_vld,
    output logic [IDX_W-1:0] first0,
    output logic [IDX_W-1:0] second0,
`ifdef FIND_ZERO_INDEX_COUNT_EN
    output logic [IDX_W-1:0] zero_cnt,
`endif
    output logic             out_vld
);

    localparam logic [IDX_W-1:0] NONE = IDX_W'(none_idx(WIDTH));

    logic [WIDTH-1:0] w_mask1;
    logic [WIDTH-1:0] w_mask2;
    logic [IDX_W-1:0] w_idx1;
    logic [IDX_W-1:0] w_idx2;
    logic             w_hit1;
    logic             w_hit2;
    logic [IDX_W-1:0] w_first;
    logic [IDX_W-1:0] w_second;

    logic [IDX_W-1:0] r_first0;
    logic [IDX_W-1:0] r_second0;
    logic             r_out_vld;

    assign w_mask1 = '1;

    zero_scan #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_scan_first (
        .vec  (in),
        .mask (w_mask1),
        .idx  (w_idx1),
        .hit  (w_hit1)
    );

    // Second scan only sees positions strictly above the first zero.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask2
        assign w_mask2[gi] = w_hit1 && (IDX_W'(gi) > w_idx1);
    end

    zero_scan #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_scan_second (
        .vec  (in),
        .mask (w_mask2),
        .idx  (w_idx2),
        .hit  (w_hit2)
    );

    assign w_first  = w_hit1 ? w_idx1 : NONE;
    assign w_second = w_hit2 ? w_idx2 : NONE;

    // Only in_vld cycles load the result, so X on an idle bus never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first0  <= NONE;
            r_second0 <= NONE;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= in_vld;
            if (in_vld) begin
                r_first0  <= w_first;
                r_second0 <= w_second;
            end
        end
    end

    assign first0  = r_first0;
    assign second0 = r_second0;
    assign out_vld = r_out_vld;

`ifdef FIND_ZERO_INDEX_COUNT_EN
    logic [IDX_W-1:0] w_cnt;
    logic [IDX_W-1:0] r_zero_cnt;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt = w_cnt + {{(IDX_W-1){1'b0}}, ~in[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_cnt <= '0;
        end else if (in_vld) begin
            r_zero_cnt <= w_cnt;
        end
    end

    assign zero_cnt = r_zero_cnt;
`endif

endmodule

// File: tb/tb_find_zero_index.sv
// Self-checking bench for find_zero_index: queue-based reference model plus directed literals.
module tb_find_zero_index;

    localparam int WIDTH = 4;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] in = '0;
    logic             in_vld = 1'b0;
    logic [IDX_W-1:0] first0;
    logic [IDX_W-1:0] second0;
    logic             out_vld;
`ifdef FIND_ZERO_INDEX_COUNT_EN
    logic [IDX_W-1:0] zero_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int m_first  = WIDTH;
    int m_second = WIDTH;
    int m_cnt    = 0;
    int m_vld    = 0;

    find_zero_index #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .in_vld  (in_vld),
        .first0  (first0),
        .second0 (second0),
`ifdef FIND_ZERO_INDEX_COUNT_EN
        .zero_cnt(zero_cnt),
`endif
        .out_vld (out_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list every zero position, then read off the first two and the count.
    task automatic model_eval(input logic [WIDTH-1:0] v, output int f, output int s, output int c);
        int q[$];
        for (int i = 0; i < WIDTH; i++) if (v[i] == 1'b0) q.push_back(i);
        f = (q.size() > 0) ? q[0] : WIDTH;
        s = (q.size() > 1) ? q[1] : WIDTH;
        c = q.size();
    endtask

    always @(posedge clk or negedge rst_n) begin
        int f, s, c;
        if (!rst_n) begin
            m_first  <= WIDTH;
            m_second <= WIDTH;
            m_cnt    <= 0;
            m_vld    <= 0;
        end else begin
            m_vld <= int'(in_vld);
            if (in_vld) begin
                model_eval(in, f, s, c);
                m_first  <= f;
                m_second <= s;
                m_cnt    <= c;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_first0", 32'(first0), 32'(m_first));
        chk("cyc_second0", 32'(second0), 32'(m_second));
        chk("cyc_out_vld", 32'(out_vld), 32'(m_vld));
`ifdef FIND_ZERO_INDEX_COUNT_EN
        chk("cyc_zero_cnt", 32'(zero_cnt), 32'(m_cnt));
`endif
        if (second0 != 3'(WIDTH)) chk("cyc_order", 32'(second0 > first0), 32'd1);
    end

    task automatic lit(input logic [WIDTH-1:0] v, input int ef, input int es);
        @(negedge clk);
        #1;
        in = v;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        $display("vec=%b first0=%0d second0=%0d out_vld=%0d", v, first0, second0, out_vld);
        chk("lit_first0", 32'(first0), 32'(ef));
        chk("lit_second0", 32'(second0), 32'(es));
        chk("lit_out_vld", 32'(out_vld), 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_first0", 32'(first0), 32'd4);
        chk("rst_second0", 32'(second0), 32'd4);
        chk("rst_out_vld", 32'(out_vld), 32'd0);

        // Release reset together with a valid sample: first edge must capture it.
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        in = 4'b0000;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_first0", 32'(first0), 32'd0);
        chk("first_edge_second0", 32'(second0), 32'd1);
        chk("first_edge_out_vld", 32'(out_vld), 32'd1);

        lit(4'b1000, 0, 1);
        lit(4'b1100, 0, 1);
        lit(4'b1110, 0, 4);
        lit(4'b1111, 4, 4);
        lit(4'b0111, 3, 4);
        lit(4'b0101, 1, 3);
`ifdef FIND_ZERO_INDEX_COUNT_EN
        chk("lit_cnt_0101", 32'(zero_cnt), 32'd2);
        lit(4'b1010, 0, 2);
        chk("lit_cnt_1010", 32'(zero_cnt), 32'd2);
        lit(4'b0101, 1, 3);
`endif

        // Hold for two idle cycles with X on the bus.
        @(negedge clk);
        #1;
        in = 'x;
        in_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            $display("hold cycle %0d first0=%0d second0=%0d out_vld=%0d", k, first0, second0, out_vld);
            chk("hold_first0", 32'(first0), 32'd1);
            chk("hold_second0", 32'(second0), 32'd3);
            chk("hold_out_vld", 32'(out_vld), 32'd0);
        end

        // Asynchronous reset mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        $display("async reset first0=%0d second0=%0d out_vld=%0d", first0, second0, out_vld);
        chk("arst_first0", 32'(first0), 32'd4);
        chk("arst_second0", 32'(second0), 32'd4);
        chk("arst_out_vld", 32'(out_vld), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        in = '0;

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            in = WIDTH'($urandom);
            in_vld = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            if (n < 8) $display("rand %0d vec=%b vld=%0d first0=%0d second0=%0d", n, in, in_vld, first0, second0);
        end

        @(negedge clk);
        #1;
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
